// File: rtl/fixed_point_square.sv
// Iterative shift-and-add squarer: signed Q16.16 operand in, unsigned Q32.32 square out.
// One partial product per cycle; fixed WIDTH-cycle latency with a level-held request/ready handshake.
module fixed_point_square #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned FRAC  = 16
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic [WIDTH-1:0]     Operand,
   input  logic                 iInputReady,
   output logic                 OutputReady,
   output logic [2*WIDTH-1:0]   Result
);

   localparam int unsigned RES_W = 2 * WIDTH;
   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

   // Result fraction bits are 2*FRAC; the arithmetic itself is format-agnostic.
   if (FRAC > WIDTH) begin : g_frac_check
      $error("fixed_point_square: FRAC must not exceed WIDTH");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOOP = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state, state_next;
   logic [RES_W-1:0]   acc, acc_next;
   logic [RES_W-1:0]   mcand, mcand_next;
   logic [WIDTH-1:0]   mplier, mplier_next;
   logic [CNT_W-1:0]   count, count_next;
   logic [RES_W-1:0]   result_next;
   logic               ready_next;
   logic [WIDTH-1:0]   mag;
   logic [RES_W-1:0]   sum;

   // State and datapath registers
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state       <= IDLE;
         acc         <= '0;
         mcand       <= '0;
         mplier      <= '0;
         count       <= '0;
         Result      <= '0;
         OutputReady <= 1'b0;
      end else begin
         state       <= state_next;
         acc         <= acc_next;
         mcand       <= mcand_next;
         mplier      <= mplier_next;
         count       <= count_next;
         Result      <= result_next;
         OutputReady <= ready_next;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_next  = state;
      acc_next    = acc;
      mcand_next  = mcand;
      mplier_next = mplier;
      count_next  = count;
      result_next = Result;
      ready_next  = OutputReady;

      // Most-negative operand negates to itself, which is the correct unsigned magnitude.
      mag = Operand[WIDTH-1] ? (~Operand + WIDTH'(1)) : Operand;
      sum = mplier[0] ? (acc + mcand) : acc;

      case (state)
         IDLE: begin
            if (iInputReady) begin
               mcand_next  = {{WIDTH{1'b0}}, mag};
               mplier_next = mag;
               acc_next    = '0;
               count_next  = '0;
               state_next  = LOOP;
            end
         end
         LOOP: begin
            acc_next    = sum;
            mcand_next  = mcand << 1;
            mplier_next = mplier >> 1;
            count_next  = count + CNT_W'(1);
            if (count == CNT_W'(WIDTH - 1)) begin
               result_next = sum;
               ready_next  = 1'b1;
               state_next  = DONE;
            end
         end
         DONE: begin
            if (!iInputReady) begin
               ready_next = 1'b0;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_fixed_point_square.sv
// Self-checking bench for fixed_point_square: directed table, handshake corner cases,
// and random operands checked against a plain-arithmetic squaring model.
module tb_fixed_point_square;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned LAT   = 32;

   logic                Clock;
   logic                Reset;
   logic [WIDTH-1:0]    Operand;
   logic                iInputReady;
   logic                OutputReady;
   logic [2*WIDTH-1:0]  Result;

   int checks = 0;
   int errors = 0;

   fixed_point_square #(.WIDTH(WIDTH), .FRAC(16)) dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .Operand     (Operand),
      .iInputReady (iInputReady),
      .OutputReady (OutputReady),
      .Result      (Result)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   typedef struct {
      logic [31:0] op;
      logic [63:0] exp;
   } vec_t;

   // Square of |x| computed with ordinary 64-bit integer arithmetic.
   function automatic logic [63:0] model_square(input logic [31:0] x);
      longint signed   sx;
      longint unsigned m;
      sx = longint'($signed(x));
      m  = (sx < 0) ? longint'(-sx) : longint'(sx);
      return m * m;
   endfunction

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Count edges until OutputReady, starting from 'start' edges already elapsed; bounded.
   task automatic wait_done(input int start, output int n);
      n = start;
      while (OutputReady !== 1'b1 && n < LAT + 20) begin
         tick();
         n++;
      end
   endtask

   // Full transaction: capture, wait, check latency/result, release, check release.
   task automatic run_txn(input string name, input logic [31:0] op, input logic [63:0] exp);
      int n;
      Operand     = op;
      iInputReady = 1'b1;
      tick();
      Operand = $urandom;
      wait_done(0, n);
      check({name, " latency"}, 64'(n), 64'(LAT));
      check({name, " result"}, Result, exp);
      iInputReady = 1'b0;
      tick();
      check({name, " release"}, 64'(OutputReady), 64'd0);
   endtask

   vec_t vecs[7];

   initial begin
      int n;
      logic [31:0] r;
      logic [63:0] hold;

      vecs[0] = '{32'h0002_0000, 64'h0000_0004_0000_0000};
      vecs[1] = '{32'hFFFF_8000, 64'h0000_0000_4000_0000};
      vecs[2] = '{32'h0001_8000, 64'h0000_0002_4000_0000};
      vecs[3] = '{32'h8000_0000, 64'h4000_0000_0000_0000};
      vecs[4] = '{32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};
      vecs[5] = '{32'h0000_0000, 64'h0000_0000_0000_0000};
      vecs[6] = '{32'h0000_8000, 64'h0000_0000_4000_0000};

      // Reset dominates a pending request
      Reset       = 1'b1;
      iInputReady = 1'b1;
      Operand     = 32'h0002_0000;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("reset ready", 64'(OutputReady), 64'd0);
         check("reset result", Result, 64'd0);
      end
      Reset = 1'b0;
      tick();
      wait_done(0, n);
      check("post-reset latency", 64'(n), 64'(LAT));
      check("basic result", Result, 64'h0000_0004_0000_0000);

      // Held request keeps OutputReady high without re-capture
      Operand = 32'h0007_0000;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hold ready", 64'(OutputReady), 64'd1);
         check("hold result", Result, 64'h0000_0004_0000_0000);
      end
      iInputReady = 1'b0;
      tick();
      check("basic release", 64'(OutputReady), 64'd0);
      check("result holds in idle", Result, 64'h0000_0004_0000_0000);

      // Directed table
      for (int i = 0; i < 7; i++) begin
         run_txn($sformatf("vec%0d", i), vecs[i].op, vecs[i].exp);
      end

      // Request dropped and operand changed mid-loop
      Operand     = 32'h0003_0000;
      iInputReady = 1'b1;
      tick();
      for (int i = 0; i < 10; i++) tick();
      check("midop ready low", 64'(OutputReady), 64'd0);
      Operand     = 32'h0005_0000;
      iInputReady = 1'b0;
      wait_done(10, n);
      check("midop latency", 64'(n), 64'(LAT));
      check("midop result", Result, 64'h0000_0009_0000_0000);
      tick();
      check("midop pulse", 64'(OutputReady), 64'd0);
      run_txn("after pulse", 32'hFFFE_0000, 64'h0000_0004_0000_0000);

      // Reset in the middle of the loop
      Operand     = 32'h0010_0000;
      iInputReady = 1'b1;
      tick();
      for (int i = 0; i < 16; i++) tick();
      Reset       = 1'b1;
      iInputReady = 1'b0;
      tick();
      check("midreset ready", 64'(OutputReady), 64'd0);
      check("midreset result", Result, 64'd0);
      Reset = 1'b0;
      tick();
      check("idle after reset", 64'(OutputReady), 64'd0);
      run_txn("after reset", 32'h0000_8000, 64'h0000_0000_4000_0000);

      // Random operands against the model, with random hold time in DONE
      for (int i = 0; i < 24; i++) begin
         r           = $urandom;
         Operand     = r;
         iInputReady = 1'b1;
         tick();
         wait_done(0, n);
         check("rand latency", 64'(n), 64'(LAT));
         check($sformatf("rand %h", r), Result, model_square(r));
         hold = Result;
         for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
            Operand = $urandom;
            tick();
         end
         check("rand hold ready", 64'(OutputReady), 64'd1);
         check("rand hold result", Result, hold);
         iInputReady = 1'b0;
         tick();
         check("rand release", 64'(OutputReady), 64'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fixed_point_square.md
# fixed_point_square

Iterative squarer: takes a signed Q16.16 operand and returns its square as an unsigned Q32.32 value. It is the inverse of the fixed-point square-root unit. Its output format matches that unit's input, so the pair round-trips to |Operand| without reformatting. It is used in the vector/lighting datapath wherever squared magnitudes are needed, and it uses the same level-held iInputReady/OutputReady handshake as the other fixed-point collateral units.

## Interface
- WIDTH, 32: operand width. The result is 2*WIDTH wide.
- FRAC, 16: operand fraction bits. The result has 2*FRAC fraction bits. Informational only; it does not change the arithmetic.
- Clock  in  1  system clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-high.
- Operand  in  WIDTH  two's-complement Q16.16; sampled only at the capture edge.
- iInputReady  in  1  request, level-held by the requester until it sees OutputReady.
- OutputReady  out  1  result valid; held until iInputReady is low.
- Result  out  2*WIDTH  unsigned Q32.32 square; register.

## Operation
- States: IDLE, LOOP, DONE.
- IDLE:
  - If iInputReady=1 at the edge: capture mag=|Operand|. Load mcand={WIDTH'b0,mag}, mplier=mag, acc=0, count=0. Go to LOOP.
  - Otherwise stay in IDLE.
- LOOP, per edge:
  - If mplier[0]=1: acc += mcand.
  - mcand <<= 1; mplier >>= 1; count++.
  - On the WIDTH-th iteration: Result <= final acc, OutputReady <= 1, go to DONE.
- DONE:
  - If iInputReady=0 at the edge: OutputReady <= 0, go to IDLE.
  - Otherwise stay in DONE.
- Arithmetic:
  - |x| = (~x)+1 for negative x.
  - |0x8000_0000| = 0x8000_0000, held unsigned in WIDTH bits.
  - acc, mcand: 2*WIDTH bits.
  - Max result 2^(2*WIDTH-2), so no overflow and no saturation is possible.
  - No rounding; the result is exact.
- Result holds its last value through IDLE and LOOP. It changes only on completion or reset.
- Operand and iInputReady are ignored in LOOP; the computation always completes.
- count width: $clog2(WIDTH)+1.

## Timing
- Reset (any state, dominates all inputs at the same edge):
  - state IDLE, OutputReady=0, Result=0, acc/mcand/mplier/count=0.
- Latency:
  - Capture edge E0.
  - OutputReady and Result become valid after edge E0+WIDTH (32 edges).
  - The latency is fixed and does not depend on the data.
- Release:
  - OutputReady falls at the first edge in DONE that samples iInputReady=0.
  - Minimum high time is 1 cycle.
- If iInputReady is dropped during LOOP: the block still completes. OutputReady is a single-cycle pulse, and the block is in IDLE on the next edge.
- Back-to-back requests: after release, the first IDLE edge with iInputReady=1 captures a new operand. Minimum request-to-request period is WIDTH+2 cycles.
- If iInputReady is still high when DONE is entered, no re-capture occurs until it has been seen low.

## Test plan
- Reset:
  - Stimulus: Reset=1 for 2 edges with iInputReady=1, Operand=0x0002_0000.
  - Required: OutputReady=0 and Result=0 throughout, no capture. After Reset drops, the capture occurs on the next edge.
- Basic request:
  - Operand=0x0002_0000 (2.0), iInputReady held high.
  - Required: exactly 32 edges after capture, Result=0x0000_0004_0000_0000 with OutputReady=1.
  - OutputReady stays high while iInputReady=1 and falls on the edge after iInputReady goes low.
- Signed and fractional values:
  - Operand=0xFFFF_8000 (-0.5) → 0x0000_0000_4000_0000.
  - Operand=0x0001_8000 (1.5) → 0x0000_0002_4000_0000. Feeding this into the square-root unit returns 0x0001_8000.
- Extremes:
  - Operand=0x8000_0000 → 0x4000_0000_0000_0000.
  - Operand=0x7FFF_FFFF → 0x3FFF_FFFF_0000_0001.
  - Operand=0 → 0, same 32-cycle latency.
- Mid-operation input changes:
  - Capture 0x0003_0000, then at LOOP cycle 10 change Operand to 0x0005_0000 and drop iInputReady.
  - Required: Result=0x0000_0009_0000_0000, OutputReady is a 1-cycle pulse, and the block is in IDLE after it.
- Reset mid-operation:
  - Assert Reset at LOOP cycle 16.
  - Required: next edge gives IDLE with OutputReady=0 and Result=0.
  - A new request with 0x0000_8000 then yields 0x0000_0000_4000_0000 after 32 edges.
